ifetch_unit: RTL and testbench

Instruction fetch front-end sitting between pc_updater and the decoder. It takes each new PC from pc_updater and issues a word read to instruction memory over a req/ack handshake. Returned words are buffered in a small FIFO, tagged with their fetch address. The decoder drains the FIFO with a valid/ready handshake; a flush input discards all buffered and in-flight fetches on a redirect.

---
 rtl/ifetch_unit_if.sv | 24 ++
 rtl/ifetch_unit.sv | 164 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request channel plus decoder issue channel.
// master = fetch unit, slave = memory/decoder side.
interface ifetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: PC -> imem req/ack -> tagged instruction FIFO -> decoder.
// Optional ack timeout enabled by defining IFETCH_TIMEOUT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no request outstanding; issues pending PC when FIFO has room
// S_REQ   | request outstanding; ack data is pushed into the FIFO
// S_DRAIN | request outstanding after a flush; ack data is discarded
module ifetch_unit #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_valid,
  input  logic            flush,
  ifetch_unit_if.master   bus,
  output logic [15:0]     fetch_count,
  output logic            fetch_fault
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("ifetch_unit: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   addr_q, pend_addr, pc_word, eff_addr;
  logic              pend_vld, eff_vld, issue, push, pop, ack, timeout;
  logic [PW-1:0]     wr_ptr, rd_ptr, head_idx;
  logic [CW-1:0]     count;
  logic [CW:0]       count_after;
  logic [XLEN+31:0]  mem [DEPTH];

  assign ack      = bus.imem_ack;
  assign pc_word  = pc & ~XLEN'(3);
  // A strobe in the current cycle is newer than anything parked in pending.
  assign eff_vld  = pc_valid | pend_vld;
  assign eff_addr = pc_valid ? pc_word : pend_addr;
  assign push     = (state == S_REQ) && ack && !flush;
  assign pop      = (count != '0) && bus.instr_ready && !flush;
  assign count_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && eff_vld && count < CW'(DEPTH)) begin
          state_n = S_REQ;
          issue   = 1'b1;
        end
      end
      S_REQ: begin
        if (flush) begin
          state_n = (ack || timeout) ? S_IDLE : S_DRAIN;
        end else if (ack) begin
          if (eff_vld && count_after < (CW+1)'(DEPTH)) begin
            state_n = S_REQ;
            issue   = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else if (timeout) begin
          state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (ack || timeout) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state != S_IDLE);
    bus.imem_addr   = addr_q;
    bus.instr_valid = (count != '0);
    // When empty, point at the slot just behind the read pointer so the
    // outputs keep showing the last instruction.
    head_idx = (count == '0) ? rd_ptr - PW'(1) : rd_ptr;
    {bus.instr_pc, bus.instr} = mem[head_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      pend_vld    <= 1'b0;
      pend_addr   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (issue) addr_q <= eff_addr;

      if (flush) begin
        pend_vld  <= pc_valid;
        pend_addr <= pc_word;
      end else if (issue) begin
        pend_vld <= 1'b0;
      end else if (pc_valid) begin
        pend_vld  <= 1'b1;
        pend_addr <= pc_word;
      end

      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {addr_q, bus.imem_rdata};
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count_after[CW-1:0];
      end

      if (push) fetch_count <= fetch_count + 16'd1;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  logic          fault_q;

  assign timeout     = (state != S_IDLE) && (tmr == '0) && !ack;
  assign fetch_fault = fault_q;

  // Down-counter reloaded on every fresh request; terminal count means the
  // TIMEOUT-th waiting cycle has been reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr     <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= timeout;
      if (state_n != S_IDLE && (state_n != state || issue))
        tmr <= TW'(TIMEOUT - 1);
      else if (state != S_IDLE && tmr != '0)
        tmr <= tmr - TW'(1);
    end
  end
`else
  assign timeout     = 1'b0;
  assign fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; expectations are hand-computed.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [15:0] fetch_count;
  logic        fetch_fault;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  ifetch_unit_if #(.XLEN(32)) bus ();

  ifetch_unit #(.XLEN(32), .DEPTH(2), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .flush       (flush),
    .bus         (bus),
    .fetch_count (fetch_count),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] a);
    pc = a;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic ack_word(input logic [31:0] d);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = d;
    tick();
    bus.imem_ack = 1'b0;
  endtask

  task automatic pop_one();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc = '0;
    pc_valid = 1'b0;
    flush = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_fault", fetch_fault, 0);
    rst = 1'b0;
    tick();

    // basic fetch, ack two cycles after req
    strobe(32'h0000_000C);
    chk("basic_req", bus.imem_req, 1);
    chk("basic_addr", bus.imem_addr, 32'h0C);
    tick();
    chk("basic_req_hold", bus.imem_req, 1);
    ack_word(32'h00A0_0093);
    chk("basic_valid", bus.instr_valid, 1);
    chk("basic_instr", bus.instr, 32'h00A0_0093);
    chk("basic_instr_pc", bus.instr_pc, 32'h0C);
    chk("basic_count", fetch_count, 1);
    chk("basic_req_done", bus.imem_req, 0);
    pop_one();
    chk("basic_empty", bus.instr_valid, 0);
    chk("basic_hold_instr", bus.instr, 32'h00A0_0093);

    // alignment
    strobe(32'd27);
    chk("align_addr", bus.imem_addr, 32'd24);
    ack_word(32'h0000_0013);
    chk("align_instr_pc", bus.instr_pc, 32'd24);
    pop_one();

    // backpressure: two buffered, third waits for a pop
    strobe(32'h10);
    tick();
    ack_word(32'h1111_0010);
    strobe(32'h14);
    chk("bp_addr2", bus.imem_addr, 32'h14);
    tick();
    ack_word(32'h1111_0014);
    strobe(32'h18);
    chk("bp_full_noreq", bus.imem_req, 0);
    tick();
    tick();
    chk("bp_full_still", bus.imem_req, 0);
    chk("bp_head0", bus.instr_pc, 32'h10);
    chk("bp_head0_instr", bus.instr, 32'h1111_0010);
    pop_one();
    chk("bp_head1", bus.instr_pc, 32'h14);
    chk("bp_noreq_pop_cycle", bus.imem_req, 0);
    tick();
    chk("bp_req3", bus.imem_req, 1);
    chk("bp_addr3", bus.imem_addr, 32'h18);
    ack_word(32'h1111_0018);
    pop_one();
    chk("bp_head2", bus.instr_pc, 32'h18);
    chk("bp_head2_valid", bus.instr_valid, 1);
    pop_one();
    chk("bp_drained", bus.instr_valid, 0);
    chk("bp_count", fetch_count, 5);

    // pending overwrite
    strobe(32'h20);
    strobe(32'h24);
    strobe(32'h28);
    tick();
    chk("ow_addr_held", bus.imem_addr, 32'h20);
    ack_word(32'h2222_0020);
    chk("ow_b2b_req", bus.imem_req, 1);
    chk("ow_b2b_addr", bus.imem_addr, 32'h28);
    ack_word(32'h2222_0028);
    chk("ow_idle", bus.imem_req, 0);
    chk("ow_head0", bus.instr_pc, 32'h20);
    pop_one();
    chk("ow_head1", bus.instr_pc, 32'h28);
    pop_one();
    chk("ow_empty", bus.instr_valid, 0);
    chk("ow_count", fetch_count, 7);

    // flush mid-request with a redirect on the same cycle
    strobe(32'h30);
    tick();
    flush = 1'b1;
    pc = 32'h100;
    pc_valid = 1'b1;
    tick();
    flush = 1'b0;
    pc_valid = 1'b0;
    chk("fl_drain_req", bus.imem_req, 1);
    chk("fl_drain_addr", bus.imem_addr, 32'h30);
    tick();
    ack_word(32'hDEAD_BEEF);
    chk("fl_dropped", bus.instr_valid, 0);
    chk("fl_count_same", fetch_count, 7);
    chk("fl_idle", bus.imem_req, 0);
    tick();
    chk("fl_redirect_req", bus.imem_req, 1);
    chk("fl_redirect_addr", bus.imem_addr, 32'h100);
    ack_word(32'h3333_0100);
    chk("fl_redirect_pc", bus.instr_pc, 32'h100);
    chk("fl_redirect_instr", bus.instr, 32'h3333_0100);
    chk("fl_count", fetch_count, 8);
    pop_one();

    // flush coinciding with ack: data dropped and buffered entry discarded
    strobe(32'h40);
    ack_word(32'h4444_0040);
    strobe(32'h44);
    flush = 1'b1;
    ack_word(32'h4444_0044);
    flush = 1'b0;
    chk("flack_empty", bus.instr_valid, 0);
    chk("flack_idle", bus.imem_req, 0);
    chk("flack_count", fetch_count, 9);

    // simultaneous push and pop
    strobe(32'h50);
    ack_word(32'h5555_0050);
    strobe(32'h54);
    bus.instr_ready = 1'b1;
    ack_word(32'h5555_0054);
    bus.instr_ready = 1'b0;
    chk("pp_valid", bus.instr_valid, 1);
    chk("pp_head", bus.instr_pc, 32'h54);
    chk("pp_instr", bus.instr, 32'h5555_0054);
    chk("pp_count", fetch_count, 11);
    pop_one();
    chk("pp_empty", bus.instr_valid, 0);

    // no ack: timeout when enabled, indefinite wait otherwise
    strobe(32'h60);
    for (int i = 0; i < 14; i++) tick();
    chk("to_req_15th", bus.imem_req, 1);
    chk("to_nofault_yet", fetch_fault, 0);
    tick();
`ifdef IFETCH_TIMEOUT_EN
    chk("to_req_drop", bus.imem_req, 0);
    chk("to_fault", fetch_fault, 1);
    tick();
    chk("to_fault_pulse", fetch_fault, 0);
    chk("to_no_valid", bus.instr_valid, 0);
    chk("to_count", fetch_count, 11);
`else
    chk("to_req_wait", bus.imem_req, 1);
    chk("to_fault_tied", fetch_fault, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("to_req_wait_long", bus.imem_req, 1);
    ack_word(32'h6666_0060);
    chk("to_late_pc", bus.instr_pc, 32'h60);
    chk("to_count", fetch_count, 12);
    pop_one();
`endif

    // asynchronous reset mid-request
    strobe(32'h70);
    chk("ar_req", bus.imem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req_drop", bus.imem_req, 0);
    chk("ar_count", fetch_count, 0);
    chk("ar_addr", bus.imem_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_idle", bus.imem_req, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
